// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin selection helper for the AXI-stream
// packet arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } arb_state_t;

    localparam int unsigned NUM_SRC_DEF = 4;
    localparam int unsigned MAX_SRC     = 8;
    localparam int unsigned MAX_IDX_W   = 3;
    localparam int unsigned SRC_IDX_W   = $clog2(NUM_SRC_DEF);

    // First requester in cyclic order starting just after `last`; keeps `last`
    // when nobody requests. Only the low num_src request bits take part.
    function automatic logic [MAX_IDX_W-1:0] next_rr(
        input logic [MAX_SRC-1:0]   req,
        input logic [MAX_IDX_W-1:0] last,
        input int unsigned          num_src
    );
        logic [MAX_IDX_W-1:0] win;
        logic                 found;
        int unsigned          idx;
        win   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_SRC; k++) begin
            idx = (32'(last) + k) % num_src;
            if (!found && (k <= num_src) && req[idx[MAX_IDX_W-1:0]]) begin
                win   = idx[MAX_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered AXI-stream skid buffer. The output side is driven
// straight from the head register; input ready is low only when both slots hold data.
module axis_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] spare_r;
    logic [1:0]       count_r;
    logic             out_valid_r;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (count_r != 2'd2);
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid_r & out_ready;
    assign out_data  = head_r;
    assign out_valid = out_valid_r;

    // Slot bookkeeping: head feeds the output, spare absorbs one beat of back-pressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r      <= '0;
            spare_r     <= '0;
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r      <= in_data;
                        count_r     <= 2'd1;
                        out_valid_r <= 1'b1;
                    end else begin
                        spare_r <= in_data;
                        count_r <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_r  <= spare_r;
                        count_r <= 2'd1;
                    end else begin
                        count_r     <= 2'd0;
                        out_valid_r <= 1'b0;
                    end
                end
                // Push and pop together only happen with one entry held.
                2'b11: begin
                    head_r <= in_data;
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI-stream producers onto
// one stream; each forwarded beat carries its source index on m_tid.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_tlast,
    output logic [ID_WIDTH-1:0]           m_tid,
    output logic                          busy,
    output logic [$clog2(NUM_SRC)-1:0]    grant_idx
);

    localparam int unsigned IDX_W  = $clog2(NUM_SRC);
    localparam int unsigned BEAT_W = DATA_WIDTH + 1 + ID_WIDTH;

    arb_state_t          state_r;
    logic [IDX_W-1:0]    grant_idx_r;
    logic [IDX_W-1:0]    last_grant_r;
    logic                busy_r;
    logic [MAX_SRC-1:0]  req_s;
    logic [IDX_W-1:0]    rr_win_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                sel_valid_s;
    logic                sel_last_s;
    logic                hit_s;
    logic                push_ready_s;
    logic                push_s;
    logic [BEAT_W-1:0]   beat_in_s;
    logic [BEAT_W-1:0]   beat_out_s;

    // Round-robin candidate from the live request vector.
    always_comb begin
        req_s              = '0;
        req_s[NUM_SRC-1:0] = s_axis_tvalid;
        rr_win_s           = IDX_W'(next_rr(req_s, MAX_IDX_W'(last_grant_r), NUM_SRC));
    end

    // Granted-source mux and per-source ready, both gated by the packet state.
    always_comb begin
        sel_data_s    = '0;
        sel_valid_s   = 1'b0;
        sel_last_s    = 1'b0;
        hit_s         = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hit_s            = (grant_idx_r == IDX_W'(i));
            sel_data_s       = sel_data_s | (s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{hit_s}});
            sel_valid_s      = sel_valid_s | (s_axis_tvalid[i] & hit_s);
            sel_last_s       = sel_last_s | (s_tlast[i] & hit_s);
            s_axis_tready[i] = (state_r == PKT) & hit_s & push_ready_s;
        end
    end

    assign push_s    = (state_r == PKT) & sel_valid_s & push_ready_s;
    assign beat_in_s = {sel_data_s, sel_last_s, ID_WIDTH'(grant_idx_r)};

    // Grant FSM: pick in IDLE, hold the grant until the granted tlast is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            grant_idx_r  <= '0;
            last_grant_r <= IDX_W'(NUM_SRC - 1);
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_idx_r  <= rr_win_s;
                        last_grant_r <= rr_win_s;
                        state_r      <= PKT;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                PKT: begin
                    if (push_s && sel_last_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= PKT;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    axis_skid_buf #(
        .WIDTH(BEAT_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (beat_in_s),
        .in_valid (push_s),
        .in_ready (push_ready_s),
        .out_data (beat_out_s),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready)
    );

    assign m_axis_tdata = beat_out_s[BEAT_W-1 -: DATA_WIDTH];
    assign m_tlast      = beat_out_s[ID_WIDTH];
    assign m_tid        = beat_out_s[ID_WIDTH-1:0];
    assign busy         = busy_r;
    assign grant_idx    = grant_idx_r;

endmodule
